instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Inverse of the decode path: takes instruction fields (format, opcode, funct3/funct7, register indices, immediate) and assembles a 32-bit RV32I/M instruction word.
- Streams assembled words into instruction memory through a sequential write port.
- Used by the boot/self-test loader to build programs in the monocycle core's instruction memory without an external assembler.
- Valid/ready input handshake, registered memory write, bounded address counter, sticky error reporting.

Parameters:
- ADDR_W, 10, instruction memory byte-address width.
- BASE_ADDR, 0, byte address of the first word written after start.
- DEPTH, 256, maximum words per program; must satisfy BASE_ADDR + 4*DEPTH <= 2**ADDR_W.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  begin a program load; honoured only in IDLE
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- in_last  in  1  bundle is the final instruction of the program
- in_fmt  in  3  format: 000 I, 001 S, 101 B, 010 U, 110 J, 011 R; 100 and 111 are illegal
- in_opcode  in  7  opcode field
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7 (R only)
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  32  byte-offset immediate, sign-extended
- im_we  out  1  instruction memory write enable
- im_addr  out  ADDR_W  byte write address, word aligned
- im_wdata  out  32  encoded instruction
- word_count  out  ADDR_W  words written in the current or last load
- done  out  1  one-cycle pulse when the load completes
- err  out  1  sticky error; cleared by start or rst

Behaviour:
- Reset: state IDLE. im_we=0, im_addr=BASE_ADDR, im_wdata=0, word_count=0, done=0, err=0, in_ready=0.
- FSM states: IDLE, RUN, FULL, DONE.
- IDLE -> RUN on start. Same edge: address pointer = BASE_ADDR, word_count=0, err=0.
- RUN: in_ready=1. A bundle is accepted on a cycle with in_valid && in_ready.
- Latency: bundle accepted at edge N -> im_we=1 with im_addr/im_wdata valid for the cycle following edge N. Then pointer += 4 and word_count += 1.
- im_we is high for exactly one cycle per written word. Back-to-back accepts give one word per cycle.
- Encoding (imm = in_imm; U uses imm[31:12]):
  - R: funct7|rs2|rs1|f3|rd|op
  - I: imm[11:0]|rs1|f3|rd|op
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op
  - U: imm[31:12]|rd|op
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op
- Illegal format, or imm[0]=1 on B/J: bundle is consumed but not written (im_we stays 0, counter unchanged), err set.
- Capacity: when word_count reaches DEPTH after a write and in_last was not set, go to FULL.
  - FULL: in_ready=0, err set, then DONE next cycle.
- in_last accepted (written or dropped) -> DONE on the following cycle.
- DONE: done=1 for one cycle, then IDLE. word_count holds until the next start.
- start outside IDLE is ignored.
- in_valid outside RUN is ignored and not consumed.
- Reset mid-load: immediate return to reset values. Words already written stay in memory; the partial load is not reported.

Optional Feature:
- Macro: INSTR_ENC_RANGE_CHECK_EN.
- When defined, the immediate is range-checked before encoding:
  - I/S: signed 12-bit.
  - B: signed 13-bit.
  - J: signed 21-bit.
  - U: imm[11:0] must be 0.
- An out-of-range bundle is dropped like an illegal format and sets err.
- When undefined, out-of-range immediates are silently truncated to the field bits and written; err is never set for range.

Test Plan:
- start; R add rd=3 rs1=1 rs2=2 op=0110011 f3=0 f7=0, then I addi rd=1 rs1=0 imm=5 op=0010011 with in_last -> two writes at addr 0, 4 with data 0x002081B3, 0x00500093; done pulse; word_count=2.
- S sw rs1=1 rs2=2 imm=8 f3=010 op=0100011 -> 0x0020A423. B beq rs1=1 rs2=2 imm=-4 f3=0 op=1100011 -> 0xFE208EE3.
- U lui rd=5 imm=0x12345000 op=0110111 -> 0x123452B7. J jal rd=1 imm=8 op=1101111 -> 0x008000EF.
- Bundles with fmt=100, and B with imm=6 (imm[0]=0, written) vs imm=5 (dropped) -> only legal words written, addresses contiguous, err=1 until the next start.
- DEPTH=4 build, 6 bundles without in_last -> 4 writes (addr 0..12), in_ready low, err=1, done pulse.
- rst asserted mid-stream after 2 writes -> all outputs at reset values immediately. Fresh start rewrites from BASE_ADDR with word_count=0.

Source files
------------

// File: rtl/instr_encoder.sv
// Assembles RV32I/M instruction words from field bundles and streams them into instruction memory.
// Optional immediate range checking is enabled by defining INSTR_ENC_RANGE_CHECK_EN.
module instr_encoder #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic [ADDR_W-1:0] word_count,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_B = 3'b101;
  localparam logic [2:0] FMT_U = 3'b010;
  localparam logic [2:0] FMT_J = 3'b110;
  localparam logic [2:0] FMT_R = 3'b011;

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] DEPTH_CNT = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FULL,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] word_count_q, word_count_d;
  logic              err_q, err_d;
  logic              im_we_q, im_we_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [31:0]       im_wdata_q, im_wdata_d;

  logic              fmt_ok;
  logic              align_ok;
  logic              range_ok;
  logic              bundle_ok;
  logic [31:0]       enc_word;
  logic [ADDR_W-1:0] count_inc;

  function automatic logic fmt_legal(input logic [2:0] fmt);
    return (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B) ||
           (fmt == FMT_U) || (fmt == FMT_J) || (fmt == FMT_R);
  endfunction

  function automatic logic [31:0] encode(
    input logic [2:0]  fmt,
    input logic [6:0]  op,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [31:0] imm
  );
    logic [31:0] w;
    w = 32'h0;
    case (fmt)
      FMT_R: w = {f7, rs2, rs1, f3, rd, op};
      FMT_I: w = {imm[11:0], rs1, f3, rd, op};
      FMT_S: w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      FMT_B: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      FMT_U: w = {imm[31:12], rd, op};
      FMT_J: w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default: w = 32'h0;
    endcase
    return w;
  endfunction

`ifdef INSTR_ENC_RANGE_CHECK_EN
  // An immediate fits a signed N-bit field when bits [31:N-1] are all copies of the sign.
  function automatic logic imm_in_range(input logic [2:0] fmt, input logic [31:0] imm);
    logic ok;
    ok = 1'b1;
    case (fmt)
      FMT_I, FMT_S: ok = (&imm[31:11]) || !(|imm[31:11]);
      FMT_B:        ok = (&imm[31:12]) || !(|imm[31:12]);
      FMT_J:        ok = (&imm[31:20]) || !(|imm[31:20]);
      FMT_U:        ok = !(|imm[11:0]);
      default:      ok = 1'b1;
    endcase
    return ok;
  endfunction

  assign range_ok = imm_in_range(in_fmt, in_imm);
`else
  assign range_ok = 1'b1;
`endif

  assign fmt_ok    = fmt_legal(in_fmt);
  assign align_ok  = !(((in_fmt == FMT_B) || (in_fmt == FMT_J)) && in_imm[0]);
  assign bundle_ok = fmt_ok && align_ok && range_ok;
  assign enc_word  = encode(in_fmt, in_opcode, in_funct3, in_funct7,
                            in_rd, in_rs1, in_rs2, in_imm);
  assign count_inc = word_count_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    word_count_d = word_count_q;
    err_d        = err_q;
    im_we_d      = 1'b0;
    im_addr_d    = im_addr_q;
    im_wdata_d   = im_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_RUN;
          ptr_d        = BASE;
          word_count_d = '0;
          err_d        = 1'b0;
        end
      end
      S_RUN: begin
        if (in_valid) begin
          if (bundle_ok) begin
            im_we_d      = 1'b1;
            im_addr_d    = ptr_q;
            im_wdata_d   = enc_word;
            ptr_d        = ptr_q + WORD_STEP;
            word_count_d = count_inc;
            if (in_last) begin
              state_d = S_DONE;
            end else if (count_inc == DEPTH_CNT) begin
              // Program overflowed the region without a terminating bundle.
              state_d = S_FULL;
              err_d   = 1'b1;
            end
          end else begin
            err_d = 1'b1;
            if (in_last) begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_FULL: begin
        err_d   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= BASE;
      word_count_q <= '0;
      err_q        <= 1'b0;
      im_we_q      <= 1'b0;
      im_addr_q    <= BASE;
      im_wdata_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      word_count_q <= word_count_d;
      err_q        <= err_d;
      im_we_q      <= im_we_d;
      im_addr_q    <= im_addr_d;
      im_wdata_q   <= im_wdata_d;
    end
  end

  assign in_ready   = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;
  assign im_we      = im_we_q;
  assign im_addr    = im_addr_q;
  assign im_wdata   = im_wdata_q;
  assign word_count = word_count_q;

endmodule
